// File: rtl/core_clint.sv
// core_clint -- core-local interruptor: free-running machine timer (mtime),
// per-hart timer compare registers (mtimecmp) and software interrupt bits (msip)
// behind a single-cycle MMIO register window.
//
// Register window (byte offsets from MMIO_BASE, 8-byte stride per hart):
//   0x0000 + 8h : msip[h]     (bit 0 only)
//   0x4000 + 8h : mtimecmp[h]
//   0xBFF8      : mtime
// With DW=32 each 64-bit register is split: low word at the offset and high
// word at offset+4. msip has no high word.
//
// Ports:
//   g_clk, g_resetn   clock, synchronous active-low reset
//   inhibit_tm        freezes prescaler and mtime
//   mmio_req/wen/addr/wdata/prv   request side (prv[0]=1 means U-mode, rejected)
//   mmio_gnt          always 1, every request is accepted
//   mmio_rdata/error  response, registered, valid the cycle after a request
//   ctr_time          current mtime
//   timer_irq         per-hart registered (mtime >= mtimecmp[h])
//   soft_irq          per-hart msip bit
module core_clint #(
  parameter logic [38:0] MMIO_BASE      = 39'h0,
  parameter int          NHARTS         = 2,
  parameter int          DW             = 64,
  parameter int          PRESCALE       = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              inhibit_tm,
  input  logic              mmio_req,
  input  logic              mmio_wen,
  input  logic [38:0]       mmio_addr,
  input  logic [DW-1:0]     mmio_wdata,
  input  logic [1:0]        mmio_prv,
  output logic              mmio_gnt,
  output logic [DW-1:0]     mmio_rdata,
  output logic              mmio_error,
  output logic [63:0]       ctr_time,
  output logic [NHARTS-1:0] timer_irq,
  output logic [NHARTS-1:0] soft_irq
);

  localparam int            CW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(PRESCALE - 1);

  // ---------------------------------------------------------------- decode
  logic [15:0] offset;
  logic [2:0]  hart_idx;
  logic        in_window;
  logic        hart_ok;
  logic        hi_word;
  logic        misaligned;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_mtime;
  logic        acc_err;
  logic        wr_ok;
  logic        write_lo;
  logic        write_hi;
  logic [63:0] wdata_ext;
  logic [31:0] w_lo;
  logic [31:0] w_hi;
  logic [63:0] rd64;
  logic [DW-1:0] rdata_word;
  logic        unused_prv;

  assign offset    = mmio_addr[15:0];
  assign hart_idx  = offset[5:3];
  assign in_window = (mmio_addr[38:16] == MMIO_BASE[38:16]);
  assign hart_ok   = ({1'b0, hart_idx} < 4'(NHARTS));

  // Only the U-mode bit decides legality; the M-mode bit is informational.
  assign unused_prv = mmio_prv[1];

  if (DW == 64) begin : g_dw64
    assign hi_word    = 1'b0;
    assign misaligned = |offset[2:0];
    assign wdata_ext  = mmio_wdata;
    assign rdata_word = rd64;
    assign write_lo   = 1'b1;
    assign write_hi   = 1'b1;
  end else begin : g_dw32
    assign hi_word    = offset[2];
    assign misaligned = |offset[1:0];
    assign wdata_ext  = {32'b0, mmio_wdata};
    assign rdata_word = hi_word ? rd64[63:32] : rd64[31:0];
    assign write_lo   = ~hi_word;
    assign write_hi   = hi_word;
  end

  // In 32-bit mode the single bus word lands in whichever half is addressed.
  assign w_lo = wdata_ext[31:0];
  assign w_hi = hi_word ? wdata_ext[31:0] : wdata_ext[63:32];

  assign sel_msip  = in_window && (offset[15:6] == 10'h000) && hart_ok && !hi_word;
  assign sel_cmp   = in_window && (offset[15:6] == 10'h100) && hart_ok;
  assign sel_mtime = in_window && (offset[15:3] == 13'h17FF);

  assign acc_err = misaligned || mmio_prv[0] || !(sel_msip || sel_cmp || sel_mtime);
  assign wr_ok   = mmio_req && mmio_wen && !acc_err;

  // ---------------------------------------------------- prescaler and mtime
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [63:0]   mtime_reg;
  logic [63:0]   mtime_next;
  logic          tick;
  logic          mtime_wr;

  assign tick     = !inhibit_tm && (count_reg == COUNT_MAX);
  assign mtime_wr = wr_ok && sel_mtime;

  // A software write wins over a coincident tick; the half not written keeps
  // its value without picking up that tick.
  always_comb begin
    count_next = count_reg;
    mtime_next = mtime_reg;
    if (mtime_wr) begin
      count_next = '0;
      mtime_next = {write_hi ? w_hi : mtime_reg[63:32],
                    write_lo ? w_lo : mtime_reg[31:0]};
    end else if (tick) begin
      count_next = '0;
      mtime_next = mtime_reg + 64'd1;
    end else if (!inhibit_tm) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      count_reg <= '0;
      mtime_reg <= '0;
    end else begin
      count_reg <= count_next;
      mtime_reg <= mtime_next;
    end
  end

  // ------------------------------------------------------- per-hart state
  logic [63:0] cmp_view [NHARTS];

  for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
    logic [63:0] mtimecmp_reg;
    logic        msip_reg;
    logic        tirq_reg;
    logic        sel_this;

    assign sel_this = (hart_idx == 3'(gi));

    always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
        mtimecmp_reg <= MTIMECMP_RESET;
        msip_reg     <= 1'b0;
        tirq_reg     <= 1'b0;
      end else begin
        if (wr_ok && sel_cmp && sel_this) begin
          if (write_lo) mtimecmp_reg[31:0]  <= w_lo;
          if (write_hi) mtimecmp_reg[63:32] <= w_hi;
        end
        if (wr_ok && sel_msip && sel_this) begin
          msip_reg <= w_lo[0];
        end
        tirq_reg <= (mtime_reg >= mtimecmp_reg);
      end
    end

    assign cmp_view[gi]  = mtimecmp_reg;
    assign timer_irq[gi] = tirq_reg;
    assign soft_irq[gi]  = msip_reg;
  end

  // ------------------------------------------------------------ read mux
  logic [63:0] cmp_rd;
  logic        msip_rd;

  always_comb begin
    cmp_rd  = '0;
    msip_rd = 1'b0;
    for (int h = 0; h < NHARTS; h++) begin
      if (hart_idx == 3'(h)) begin
        cmp_rd  = cmp_view[h];
        msip_rd = soft_irq[h];
      end
    end
    rd64 = '0;
    if (sel_mtime) begin
      rd64 = mtime_reg;
    end else if (sel_cmp) begin
      rd64 = cmp_rd;
    end else if (sel_msip) begin
      rd64 = {63'b0, msip_rd};
    end
  end

  // ------------------------------------------------------------- response
  logic [DW-1:0] rdata_reg;
  logic          error_reg;

  // Error reflects the latest request; read data only moves on a clean read.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rdata_reg <= '0;
      error_reg <= 1'b0;
    end else if (mmio_req) begin
      error_reg <= acc_err;
      if (!mmio_wen && !acc_err) begin
        rdata_reg <= rdata_word;
      end
    end
  end

  assign mmio_gnt   = 1'b1;
  assign mmio_rdata = rdata_reg;
  assign mmio_error = error_reg;
  assign ctr_time   = mtime_reg;

endmodule

// File: tb/tb_core_clint.sv
// Directed testbench for core_clint: a 64-bit / PRESCALE=4 instance for the
// main scenarios and a 32-bit / PRESCALE=1 instance at a non-zero base for the
// split-register behaviour. Inputs change on the falling edge, outputs are
// checked on the falling edge after the capturing rising edge.
module tb_core_clint;

  localparam logic [38:0] B32 = 39'h200_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        inh64, req64, wen64;
  logic [38:0] addr64;
  logic [63:0] wd64;
  logic [1:0]  prv64;
  logic        gnt64, err64;
  logic [63:0] rd64, time64;
  logic [1:0]  tirq64, sirq64;

  logic        inh32, req32, wen32;
  logic [38:0] addr32;
  logic [31:0] wd32;
  logic [1:0]  prv32;
  logic        gnt32, err32;
  logic [31:0] rd32;
  logic [63:0] time32;
  logic [1:0]  tirq32, sirq32;

  int n_cmp = 0;
  int n_bad = 0;

  core_clint #(.MMIO_BASE(39'h0), .NHARTS(2), .DW(64), .PRESCALE(4)) u64 (
    .g_clk(clk), .g_resetn(resetn), .inhibit_tm(inh64),
    .mmio_req(req64), .mmio_wen(wen64), .mmio_addr(addr64), .mmio_wdata(wd64),
    .mmio_prv(prv64), .mmio_gnt(gnt64), .mmio_rdata(rd64), .mmio_error(err64),
    .ctr_time(time64), .timer_irq(tirq64), .soft_irq(sirq64)
  );

  core_clint #(.MMIO_BASE(B32), .NHARTS(2), .DW(32), .PRESCALE(1)) u32 (
    .g_clk(clk), .g_resetn(resetn), .inhibit_tm(inh32),
    .mmio_req(req32), .mmio_wen(wen32), .mmio_addr(addr32), .mmio_wdata(wd32),
    .mmio_prv(prv32), .mmio_gnt(gnt32), .mmio_rdata(rd32), .mmio_error(err32),
    .ctr_time(time32), .timer_irq(tirq32), .soft_irq(sirq32)
  );

  task automatic drive64(input logic w, input logic [38:0] a, input logic [63:0] d,
                         input logic [1:0] p);
    req64 = 1'b1; wen64 = w; addr64 = a; wd64 = d; prv64 = p;
    @(negedge clk);
    $display("txn64 %s addr=%h wdata=%h prv=%b -> err=%b rdata=%h",
             w ? "WR" : "RD", a, d, p, err64, rd64);
  endtask

  task automatic idle64();
    req64 = 1'b0; wen64 = 1'b0;
  endtask

  task automatic drive32(input logic w, input logic [38:0] a, input logic [31:0] d,
                         input logic [1:0] p);
    req32 = 1'b1; wen32 = w; addr32 = a; wd32 = d; prv32 = p;
    @(negedge clk);
    $display("txn32 %s addr=%h wdata=%h prv=%b -> err=%b rdata=%h",
             w ? "WR" : "RD", a, d, p, err32, rd32);
  endtask

  task automatic idle32();
    req32 = 1'b0; wen32 = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    // requests presented during reset must leave no trace
    req64 = 1'b1; wen64 = 1'b1; addr64 = 39'h0; wd64 = 64'h1; prv64 = 2'b01;
    req32 = 1'b1; wen32 = 1'b1; addr32 = B32;   wd32 = 32'h1; prv32 = 2'b10;
    repeat (2) @(negedge clk);
    resetn = 1'b1; idle64(); idle32();
    n_cmp++; if (time64 !== 64'd0)  begin n_bad++; $display("FAIL rst_time64 got=%h exp=0", time64); end
    n_cmp++; if (tirq64 !== 2'b00)  begin n_bad++; $display("FAIL rst_tirq64 got=%b exp=00", tirq64); end
    n_cmp++; if (sirq64 !== 2'b00)  begin n_bad++; $display("FAIL rst_sirq64 got=%b exp=00", sirq64); end
    n_cmp++; if (err64 !== 1'b0)    begin n_bad++; $display("FAIL rst_err64 got=%b exp=0", err64); end
    n_cmp++; if (rd64 !== 64'd0)    begin n_bad++; $display("FAIL rst_rd64 got=%h exp=0", rd64); end
    n_cmp++; if (gnt64 !== 1'b1)    begin n_bad++; $display("FAIL gnt64 got=%b exp=1", gnt64); end
    n_cmp++; if (time32 !== 64'd0)  begin n_bad++; $display("FAIL rst_time32 got=%h exp=0", time32); end
    n_cmp++; if (sirq32 !== 2'b00)  begin n_bad++; $display("FAIL rst_sirq32 got=%b exp=00", sirq32); end
    n_cmp++; if (err32 !== 1'b0)    begin n_bad++; $display("FAIL rst_err32 got=%b exp=0", err32); end
  endtask

  task automatic test_prescale();
    repeat (3) @(negedge clk);
    n_cmp++; if (time64 !== 64'd0) begin n_bad++; $display("FAIL presc_3cyc got=%h exp=0", time64); end
    @(negedge clk);
    n_cmp++; if (time64 !== 64'd1) begin n_bad++; $display("FAIL presc_4cyc got=%h exp=1", time64); end
    repeat (3) @(negedge clk);
    n_cmp++; if (time64 !== 64'd1) begin n_bad++; $display("FAIL presc_7cyc got=%h exp=1", time64); end
    @(negedge clk);
    n_cmp++; if (time64 !== 64'd2) begin n_bad++; $display("FAIL presc_8cyc got=%h exp=2", time64); end
    repeat (2) @(negedge clk);
    inh64 = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (time64 !== 64'd2) begin n_bad++; $display("FAIL inhibit_hold got=%h exp=2", time64); end
    inh64 = 1'b0;
    @(negedge clk);
    n_cmp++; if (time64 !== 64'd2) begin n_bad++; $display("FAIL inhibit_cnt3 got=%h exp=2", time64); end
    @(negedge clk);
    n_cmp++; if (time64 !== 64'd3) begin n_bad++; $display("FAIL inhibit_resume got=%h exp=3", time64); end
  endtask

  task automatic test_timer();
    drive64(1'b1, 39'hBFF8, 64'd0, 2'b10);
    drive64(1'b1, 39'h4008, 64'd5, 2'b10);
    idle64();
    repeat (19) @(negedge clk);
    n_cmp++; if (time64 !== 64'd5) begin n_bad++; $display("FAIL timer_mtime got=%h exp=5", time64); end
    n_cmp++; if (tirq64 !== 2'b00) begin n_bad++; $display("FAIL timer_early got=%b exp=00", tirq64); end
    @(negedge clk);
    n_cmp++; if (tirq64 !== 2'b10) begin n_bad++; $display("FAIL timer_set got=%b exp=10", tirq64); end
    drive64(1'b0, 39'h4008, 64'd0, 2'b10); idle64();
    n_cmp++; if (rd64 !== 64'd5) begin n_bad++; $display("FAIL cmp1_read got=%h exp=5", rd64); end
  endtask

  task automatic test_soft();
    inh64 = 1'b1;
    drive64(1'b1, 39'hBFF8, 64'h1234, 2'b10);
    n_cmp++; if (time64 !== 64'h1234) begin n_bad++; $display("FAIL mtime_load got=%h exp=1234", time64); end
    drive64(1'b1, 39'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
    idle64();
    n_cmp++; if (sirq64 !== 2'b01) begin n_bad++; $display("FAIL soft_set got=%b exp=01", sirq64); end
    drive64(1'b0, 39'h0000, 64'd0, 2'b10); idle64();
    n_cmp++; if (rd64 !== 64'h1) begin n_bad++; $display("FAIL msip0_read got=%h exp=1", rd64); end
    drive64(1'b0, 39'h0008, 64'd0, 2'b10); idle64();
    n_cmp++; if (rd64 !== 64'h0) begin n_bad++; $display("FAIL msip1_read got=%h exp=0", rd64); end
  endtask

  task automatic test_errors();
    drive64(1'b0, 39'hBFF8, 64'd0, 2'b10); idle64();
    n_cmp++; if (rd64 !== 64'h1234) begin n_bad++; $display("FAIL mtime_read got=%h exp=1234", rd64); end
    drive64(1'b1, 39'hBFF8, 64'hDEAD, 2'b01); idle64();
    n_cmp++; if (err64 !== 1'b1)    begin n_bad++; $display("FAIL umode_err got=%b exp=1", err64); end
    n_cmp++; if (rd64 !== 64'h1234) begin n_bad++; $display("FAIL umode_rd got=%h exp=1234", rd64); end
    @(negedge clk);
    n_cmp++; if (err64 !== 1'b1)      begin n_bad++; $display("FAIL err_hold got=%b exp=1", err64); end
    n_cmp++; if (time64 !== 64'h1234) begin n_bad++; $display("FAIL umode_mtime got=%h exp=1234", time64); end
    drive64(1'b0, 39'h0004, 64'd0, 2'b10); idle64();
    n_cmp++; if (err64 !== 1'b1)    begin n_bad++; $display("FAIL misalign_err got=%b exp=1", err64); end
    n_cmp++; if (rd64 !== 64'h1234) begin n_bad++; $display("FAIL misalign_rd got=%h exp=1234", rd64); end
    drive64(1'b0, 39'h3000, 64'd0, 2'b10); idle64();
    n_cmp++; if (err64 !== 1'b1) begin n_bad++; $display("FAIL hole_err got=%b exp=1", err64); end
    drive64(1'b0, 39'h1_0000, 64'd0, 2'b10); idle64();
    n_cmp++; if (err64 !== 1'b1) begin n_bad++; $display("FAIL window_err got=%b exp=1", err64); end
    drive64(1'b0, 39'h0010, 64'd0, 2'b10); idle64();
    n_cmp++; if (err64 !== 1'b1) begin n_bad++; $display("FAIL hart2_err got=%b exp=1", err64); end
    drive64(1'b1, 39'h0008, 64'd1, 2'b01); idle64();
    n_cmp++; if (sirq64 !== 2'b01) begin n_bad++; $display("FAIL umode_msip got=%b exp=01", sirq64); end
    drive64(1'b0, 39'hBFF8, 64'd0, 2'b10); idle64();
    n_cmp++; if (err64 !== 1'b0)    begin n_bad++; $display("FAIL err_clear got=%b exp=0", err64); end
    n_cmp++; if (rd64 !== 64'h1234) begin n_bad++; $display("FAIL mtime_kept got=%h exp=1234", rd64); end
  endtask

  task automatic test_back_to_back();
    drive64(1'b1, 39'h4000, 64'h55, 2'b10);
    n_cmp++; if (err64 !== 1'b0)    begin n_bad++; $display("FAIL b2b_w_err got=%b exp=0", err64); end
    n_cmp++; if (rd64 !== 64'h1234) begin n_bad++; $display("FAIL b2b_w_rd got=%h exp=1234", rd64); end
    n_cmp++; if (tirq64 !== 2'b10)  begin n_bad++; $display("FAIL b2b_tirq1 got=%b exp=10", tirq64); end
    drive64(1'b0, 39'h4000, 64'd0, 2'b10);
    n_cmp++; if (rd64 !== 64'h55)   begin n_bad++; $display("FAIL b2b_cmp_rd got=%h exp=55", rd64); end
    n_cmp++; if (tirq64 !== 2'b11)  begin n_bad++; $display("FAIL b2b_tirq2 got=%b exp=11", tirq64); end
    drive64(1'b0, 39'h0004, 64'd0, 2'b10);
    n_cmp++; if (err64 !== 1'b1)    begin n_bad++; $display("FAIL b2b_err got=%b exp=1", err64); end
    n_cmp++; if (rd64 !== 64'h55)   begin n_bad++; $display("FAIL b2b_err_rd got=%h exp=55", rd64); end
    drive64(1'b0, 39'h0000, 64'd0, 2'b10);
    idle64();
    n_cmp++; if (err64 !== 1'b0)    begin n_bad++; $display("FAIL b2b_last_err got=%b exp=0", err64); end
    n_cmp++; if (rd64 !== 64'h1)    begin n_bad++; $display("FAIL b2b_last_rd got=%h exp=1", rd64); end
  endtask

  task automatic test_reset_mid();
    inh64 = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tirq64 !== 2'b11) begin n_bad++; $display("FAIL pre_rst_tirq got=%b exp=11", tirq64); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_cmp++; if (time64 !== 64'd0) begin n_bad++; $display("FAIL mid_rst_time got=%h exp=0", time64); end
    n_cmp++; if (tirq64 !== 2'b00) begin n_bad++; $display("FAIL mid_rst_tirq got=%b exp=00", tirq64); end
    n_cmp++; if (sirq64 !== 2'b00) begin n_bad++; $display("FAIL mid_rst_sirq got=%b exp=00", sirq64); end
    n_cmp++; if (rd64 !== 64'd0)   begin n_bad++; $display("FAIL mid_rst_rd got=%h exp=0", rd64); end
    n_cmp++; if (err64 !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_err got=%b exp=0", err64); end
    drive64(1'b0, 39'h4000, 64'd0, 2'b10); idle64();
    n_cmp++; if (rd64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL cmp_rst_val got=%h exp=ffffffffffffffff", rd64); end
    n_cmp++; if (tirq64 !== 2'b00) begin n_bad++; $display("FAIL post_rst_tirq got=%b exp=00", tirq64); end
  endtask

  task automatic test_dw32();
    drive32(1'b1, B32 + 39'hBFFC, 32'h0, 2'b10);
    drive32(1'b1, B32 + 39'hBFF8, 32'hFFFF_FFFF, 2'b10);
    idle32();
    n_cmp++; if (time32 !== 64'h0000_0000_FFFF_FFFF) begin n_bad++; $display("FAIL dw32_load got=%h exp=00000000ffffffff", time32); end
    @(negedge clk);
    n_cmp++; if (time32 !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL dw32_carry got=%h exp=0000000100000000", time32); end
    drive32(1'b0, B32 + 39'hBFFC, 32'h0, 2'b10); idle32();
    n_cmp++; if (rd32 !== 32'h1)  begin n_bad++; $display("FAIL dw32_hi_rd got=%h exp=1", rd32); end
    n_cmp++; if (err32 !== 1'b0)  begin n_bad++; $display("FAIL dw32_hi_err got=%b exp=0", err32); end
    drive32(1'b1, B32 + 39'hBFF8, 32'h100, 2'b10); idle32();
    n_cmp++; if (time32 !== 64'h0000_0001_0000_0100) begin n_bad++; $display("FAIL dw32_tick_wr got=%h exp=0000000100000100", time32); end
    @(negedge clk);
    n_cmp++; if (time32 !== 64'h0000_0001_0000_0101) begin n_bad++; $display("FAIL dw32_after_wr got=%h exp=0000000100000101", time32); end
    drive32(1'b1, B32 + 39'h8, 32'h1, 2'b10); idle32();
    n_cmp++; if (sirq32 !== 2'b10) begin n_bad++; $display("FAIL dw32_msip1 got=%b exp=10", sirq32); end
    drive32(1'b0, B32 + 39'h8, 32'h0, 2'b10); idle32();
    n_cmp++; if (rd32 !== 32'h1)   begin n_bad++; $display("FAIL dw32_msip_rd got=%h exp=1", rd32); end
    drive32(1'b1, B32 + 39'hC, 32'h0, 2'b10); idle32();
    n_cmp++; if (err32 !== 1'b1)   begin n_bad++; $display("FAIL dw32_msip_hi got=%b exp=1", err32); end
    n_cmp++; if (sirq32 !== 2'b10) begin n_bad++; $display("FAIL dw32_msip_keep got=%b exp=10", sirq32); end
    drive32(1'b0, B32 + 39'h4004, 32'h0, 2'b10); idle32();
    n_cmp++; if (rd32 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dw32_cmp_hi got=%h exp=ffffffff", rd32); end
    drive32(1'b1, B32 + 39'h4004, 32'h0, 2'b10); idle32();
    n_cmp++; if (tirq32 !== 2'b00) begin n_bad++; $display("FAIL dw32_tirq_early got=%b exp=00", tirq32); end
    @(negedge clk);
    n_cmp++; if (tirq32 !== 2'b01) begin n_bad++; $display("FAIL dw32_tirq got=%b exp=01", tirq32); end
    drive32(1'b0, B32 + 39'hBFFA, 32'h0, 2'b10); idle32();
    n_cmp++; if (err32 !== 1'b1) begin n_bad++; $display("FAIL dw32_misalign got=%b exp=1", err32); end
    drive32(1'b0, 39'hBFF8, 32'h0, 2'b10); idle32();
    n_cmp++; if (err32 !== 1'b1) begin n_bad++; $display("FAIL dw32_window got=%b exp=1", err32); end
  endtask

  initial begin
    resetn = 1'b0;
    inh64 = 1'b0; req64 = 1'b0; wen64 = 1'b0; addr64 = '0; wd64 = '0; prv64 = 2'b10;
    inh32 = 1'b0; req32 = 1'b0; wen32 = 1'b0; addr32 = '0; wd32 = '0; prv32 = 2'b10;
    test_reset();
    test_prescale();
    test_timer();
    test_soft();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_dw32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
